// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - synchronous-read instruction memory with program-load port
// Registered fetch with stall/flush; misaligned and out-of-range PCs are flagged.
module instr_mem_sync #(
    parameter int              XLEN   = 32,
    parameter int              ADDR_W = 10,
    parameter logic [XLEN-1:0] NOP    = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              flush,
    input  logic              load_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [XLEN-1:0]   prog_data,
    output logic [XLEN-1:0]   instr,
    output logic [XLEN-1:0]   instr_pc,
    output logic              instr_valid,
    output logic              fault_misal,
    output logic              fault_oob
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [XLEN-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              misal;
    logic              oob;

    assign idx   = pc[ADDR_W+1:2];
    assign misal = (pc[1:0] != 2'b00);
    assign oob   = |pc[XLEN-1:ADDR_W+2];

    // Storage has no reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && load_mode && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || load_mode) begin
            instr       <= NOP;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fault_misal <= 1'b0;
            fault_oob   <= 1'b0;
        end else if (flush) begin
            instr       <= NOP;
            instr_valid <= 1'b0;
            fault_misal <= 1'b0;
            fault_oob   <= 1'b0;
        end else if (stall) begin
            instr       <= instr;
            instr_pc    <= instr_pc;
            instr_valid <= instr_valid;
            fault_misal <= fault_misal;
            fault_oob   <= fault_oob;
        end else if (fetch_en) begin
            // A faulting fetch still reports valid but never exposes memory data.
            instr       <= (misal || oob) ? NOP : mem[idx];
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            fault_misal <= misal;
            fault_oob   <= oob;
        end else begin
            instr       <= NOP;
            instr_valid <= 1'b0;
            fault_misal <= 1'b0;
            fault_oob   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb/tb_instr_mem_sync.sv - scoreboard bench for instr_mem_sync
// Driver queues expected outputs per cycle; a negedge monitor pops and compares.
module tb_instr_mem_sync;

    localparam logic [31:0] NOPW = 32'h00000013;
    localparam logic [31:0] W0 = 32'h009684B3;
    localparam logic [31:0] W1 = 32'h409684B3;
    localparam logic [31:0] W2 = 32'h00A00093;
    localparam logic [31:0] W3 = 32'h00B00113;
    localparam logic [31:0] W5 = 32'h00500293;
    localparam logic [31:0] WX = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset, fetch_en, stall, flush, load_mode, prog_we;
    logic [31:0] pc, prog_data;
    logic [9:0]  prog_addr;
    logic [31:0] instr, instr_pc;
    logic        instr_valid, fault_misal, fault_oob;

    typedef struct {
        int          cyc;
        logic [31:0] i;
        logic [31:0] p;
        logic        v;
        logic        m;
        logic        o;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    instr_mem_sync dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .stall(stall),
        .flush(flush), .load_mode(load_mode), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid),
        .fault_misal(fault_misal), .fault_oob(fault_oob)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (e.cyc != cyc || instr !== e.i || instr_pc !== e.p || instr_valid !== e.v
                || fault_misal !== e.m || fault_oob !== e.o) begin
                n_bad++;
                $display("FAIL %s: got instr=%h pc=%h v=%b m=%b o=%b want instr=%h pc=%h v=%b m=%b o=%b (cyc %0d/%0d)",
                         e.nm, instr, instr_pc, instr_valid, fault_misal, fault_oob,
                         e.i, e.p, e.v, e.m, e.o, cyc, e.cyc);
            end
        end
    end

    task automatic step(input logic r, input logic lm, input logic we,
                        input logic [9:0] pa, input logic [31:0] pd,
                        input logic fe, input logic st, input logic fl,
                        input logic [31:0] p, input bit chk, input string nm,
                        input logic [31:0] ei, input logic [31:0] ep,
                        input logic ev, input logic em, input logic eo);
        exp_t e;
        reset = r; load_mode = lm; prog_we = we; prog_addr = pa; prog_data = pd;
        fetch_en = fe; stall = st; flush = fl; pc = p;
        if (chk) begin
            e.cyc = cyc + 1; e.i = ei; e.p = ep; e.v = ev; e.m = em; e.o = eo; e.nm = nm;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_mode = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        fetch_en = 1'b0; stall = 1'b0; flush = 1'b0; pc = '0;
        @(posedge clk);
        #1;
        //   r  lm we addr data   fe st fl pc        chk name            instr pc        v  m  o
        step(1, 0, 0, 0, 0,       0, 0, 0, 0,        1, "reset",         NOPW, 0,        0, 0, 0);
        step(0, 1, 1, 0, W0,      1, 0, 0, 4,        1, "load_w0",       NOPW, 0,        0, 0, 0);
        step(0, 1, 1, 1, W1,      1, 0, 0, 4,        1, "load_w1",       NOPW, 0,        0, 0, 0);
        step(0, 1, 1, 2, W2,      0, 0, 0, 0,        1, "load_w2",       NOPW, 0,        0, 0, 0);
        step(0, 1, 1, 3, W3,      0, 0, 0, 0,        1, "load_w3",       NOPW, 0,        0, 0, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 0,        1, "fetch_pc0",     W0,   0,        1, 0, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 4,        1, "fetch_pc4",     W1,   4,        1, 0, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 8,        1, "fetch_pc8",     W2,   8,        1, 0, 0);
        for (int k = 0; k < 3; k++)
            step(0, 0, 0, 0, 0,   1, 1, 0, 12,       1, "stall_hold",    W2,   8,        1, 0, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 12,       1, "stall_release", W3,   12,       1, 0, 0);
        step(0, 0, 0, 0, 0,       1, 1, 1, 0,        1, "flush_stall",   NOPW, 12,       0, 0, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 6,        1, "misal",         NOPW, 6,        1, 1, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 32'h1000, 1, "oob",           NOPW, 32'h1000, 1, 0, 1);
        step(0, 0, 0, 0, 0,       1, 0, 0, 32'h1002, 1, "misal_oob",     NOPW, 32'h1002, 1, 1, 1);
        step(0, 0, 0, 0, 0,       1, 1, 0, 0,        1, "stall_faults",  NOPW, 32'h1002, 1, 1, 1);
        step(0, 0, 0, 0, 0,       1, 0, 1, 0,        1, "flush_faults",  NOPW, 32'h1002, 0, 0, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 4,        1, "refetch_pc4",   W1,   4,        1, 0, 0);
        step(0, 0, 0, 0, 0,       0, 0, 0, 8,        1, "fetch_idle",    NOPW, 4,        0, 0, 0);
        step(0, 1, 1, 5, W5,      0, 0, 0, 0,        1, "load_w5",       NOPW, 0,        0, 0, 0);
        step(1, 1, 1, 5, WX,      0, 0, 0, 0,        1, "reset_in_load", NOPW, 0,        0, 0, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 20,       1, "read_w5",       W5,   20,       1, 0, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 0,        1, "read_w0_kept",  W0,   0,        1, 0, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 4,        1, "fetch_b4rst",   W1,   4,        1, 0, 0);
        step(1, 0, 0, 0, 0,       1, 1, 0, 8,        1, "reset_stall",   NOPW, 0,        0, 0, 0);
        step(0, 0, 1, 0, WX,      1, 0, 0, 4,        1, "we_in_fetch",   W1,   4,        1, 0, 0);
        step(0, 0, 0, 0, 0,       1, 0, 0, 0,        1, "w0_unchanged",  W0,   0,        1, 0, 0);
        step(0, 0, 0, 0, 0,       0, 0, 0, 0,        0, "",              NOPW, 0,        0, 0, 0);
        step(0, 0, 0, 0, 0,       0, 0, 0, 0,        0, "",              NOPW, 0,        0, 0, 0);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
